// File: rtl/inv_engine_arbiter.sv
// inv_engine_arbiter
//   Shares one modular-inverse engine between NUM_REQ requesters. The arbiter
//   accepts one request at a time, picking round-robin among pending
//   requesters. It pulses the engine start and waits for done or a timeout,
//   then returns the result to the owner.
//
//   Every control output (req_ready, eng_start, resp_valid) is registered.
//   Each one therefore appears in the cycle after the state that decides it.
//
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     req_valid/a/prime    per-requester request, packed 8-bit slices
//     req_ready            one-hot accept pulse
//     resp_valid           one-hot response pulse to the owner
//     resp_data/resp_err   result and error flag (held until next update)
//     eng_start/a/prime    engine start pulse and operands
//     eng_done/result      engine completion and result
//     busy                 FSM is not IDLE
//
//   Optional feature: define INV_ARB_ZERO_CHECK_EN to short-circuit requests
//   with a == 0 or prime < 2 straight to an error response.
module inv_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_prime,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_data,
  output logic                 resp_err,
  output logic                 eng_start,
  output logic [7:0]           eng_a,
  output logic [7:0]           eng_prime,
  input  logic                 eng_done,
  input  logic [7:0]           eng_result,
  output logic                 busy
);

  // state   | meaning
  // IDLE    | waiting for any req_valid; accept round-robin winner
  // ISSUE   | start the engine, load timeout counter
  // WAIT    | wait for eng_done or timeout
  // RESP    | answer the owner, advance round-robin pointer
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_d;
  logic [IDX_W-1:0]   owner, owner_d;
  logic [CNT_W-1:0]   timer, timer_d;
  logic [NUM_REQ-1:0] ready_d, rvalid_d;
  logic [7:0]         rdata_d, a_d, p_d;
  logic               rerr_d, start_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   scan_idx;
  logic [7:0]         a_sel, p_sel;

  // Scan upward from rr_ptr with wrap; first pending requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    a_sel    = '0;
    p_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == IDX_W'(j)) begin
        a_sel = req_a[8*j +: 8];
        p_sel = req_prime[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state;
    rr_d     = rr_ptr;
    owner_d  = owner;
    timer_d  = timer;
    ready_d  = '0;
    rvalid_d = '0;
    rdata_d  = resp_data;
    rerr_d   = resp_err;
    start_d  = 1'b0;
    a_d      = eng_a;
    p_d      = eng_prime;
    case (state)
      S_IDLE: begin
        if (found) begin
          ready_d[winner] = 1'b1;
          a_d             = a_sel;
          p_d             = p_sel;
          owner_d         = winner;
`ifdef INV_ARB_ZERO_CHECK_EN
          if (a_sel == 8'd0 || p_sel < 8'd2) begin
            rdata_d = 8'd0;
            rerr_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        // Down-counter: terminal count 0 marks the TIMEOUT-th WAIT cycle.
        timer_d = CNT_W'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (eng_done) begin
          rdata_d = eng_result;
          rerr_d  = 1'b0;
          state_d = S_RESP;
        end else if (timer == '0) begin
          rdata_d = 8'd0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer - CNT_W'(1);
        end
      end
      S_RESP: begin
        rvalid_d[owner] = 1'b1;
        rr_d    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      timer      <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      eng_start  <= 1'b0;
      eng_a      <= '0;
      eng_prime  <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_d;
      owner      <= owner_d;
      timer      <= timer_d;
      req_ready  <= ready_d;
      resp_valid <= rvalid_d;
      resp_data  <= rdata_d;
      resp_err   <= rerr_d;
      eng_start  <= start_d;
      eng_a      <= a_d;
      eng_prime  <= p_d;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_inv_engine_arbiter.sv
module tb_inv_engine_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a, req_prime;
  logic [NUM_REQ-1:0]   req_ready, resp_valid;
  logic [7:0]           resp_data;
  logic                 resp_err;
  logic                 eng_start;
  logic [7:0]           eng_a, eng_prime;
  logic                 eng_done;
  logic [7:0]           eng_result;
  logic                 busy;

  inv_engine_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_prime(req_prime),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_prime(eng_prime),
    .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int resp_cnt  = 0;
  int push_cnt  = 0;
  int start_cnt = 0;

  int         eng_delay = 0;
  int         eng_cnt   = 0;
  logic [7:0] eng_res   = 8'h00;
  bit         eng_stray = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Engine model: done pulses eng_delay cycles after eng_start is seen;
  // eng_delay == 0 means the engine never answers.
  initial begin
    eng_done   = 1'b0;
    eng_result = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (eng_stray) begin
        eng_done   = 1'b1;
        eng_result = 8'hEE;
        eng_stray  = 1'b0;
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = eng_res;
        end
      end
      if (eng_start) begin
        start_cnt++;
        if (eng_delay > 0) eng_cnt = eng_delay;
      end
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid != '0) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", int'(resp_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_owner", int'(resp_valid), 1 << mon_e.idx);
        check("resp_data", int'(resp_data), int'(mon_e.data));
        check("resp_err", int'(resp_err), int'(mon_e.err));
        check("resp_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] p);
    req_valid[i]       = 1'b1;
    req_a[8*i +: 8]     = a;
    req_prime[8*i +: 8] = p;
  endtask

  task automatic wait_ready(output int idx);
    idx = -1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready != '0) begin
        for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) idx = j;
        return;
      end
      tick();
    end
  endtask

  task automatic expect_resp(input int idx, input logic [7:0] data, input logic err, input int lat);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    e.err  = err;
    e.due  = cyc + lat;
    exp_q.push_back(e);
    push_cnt++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int g;
  int s0;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_prime = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_data", int'(resp_data), 0);
    check("rst_resp_err", int'(resp_err), 0);
    check("rst_eng_start", int'(eng_start), 0);
    check("rst_eng_a", int'(eng_a), 0);
    check("rst_eng_prime", int'(eng_prime), 0);

    // Single request: 3^-1 mod 7 = 5, engine answers after 5 cycles
    eng_delay = 5; eng_res = 8'd5;
    s0 = start_cnt;
    set_req(0, 8'd3, 8'd7);
    wait_ready(g);
    check("t1_grant", g, 0);
    expect_resp(0, 8'd5, 1'b0, 3 + 5);
    req_valid[0] = 1'b0;
    tick();
    check("t1_ready_pulse", int'(req_ready), 0);
    check("t1_eng_a", int'(eng_a), 3);
    check("t1_eng_prime", int'(eng_prime), 7);
    check("t1_busy", int'(busy), 1);
    wait_drain();
    check("t1_starts", start_cnt - s0, 1);
    tick();
    check("t1_data_hold", int'(resp_data), 5);

    // Round robin from a fresh pointer: 10^-1 mod 17 = 12
    do_reset();
    eng_delay = 3; eng_res = 8'd12;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'd10, 8'd17);
    for (int k = 0; k < 5; k++) begin
      wait_ready(g);
      check("rr_grant", g, k % NUM_REQ);
      if (g >= 0) expect_resp(g, 8'd12, 1'b0, 3 + 3);
      if (k == 4) req_valid = '0;
      tick();
    end
    wait_drain();

    // Timeout: engine silent, then a stray done must be ignored
    eng_delay = 0;
    set_req(2, 8'd9, 8'd13);
    wait_ready(g);
    check("to_grant", g, 2);
    expect_resp(2, 8'd0, 1'b1, TIMEOUT + 2);
    req_valid[2] = 1'b0;
    tick();
    wait_drain();
    eng_stray = 1'b1;
    repeat (5) tick();
    check("to_stray_ignored", resp_cnt, push_cnt);
    check("to_stray_busy", int'(busy), 0);
    check("to_stray_data", int'(resp_data), 0);
    check("to_stray_err", int'(resp_err), 1);

    // Done coincides with the last WAIT cycle: done wins
    eng_delay = TIMEOUT - 1; eng_res = 8'h2A;
    set_req(1, 8'd7, 8'd11);
    wait_ready(g);
    check("co_grant", g, 1);
    expect_resp(1, 8'h2A, 1'b0, TIMEOUT + 2);
    req_valid[1] = 1'b0;
    tick();
    wait_drain();

    // Reset while waiting: no response, pointer back to 0
    eng_delay = 0;
    set_req(3, 8'd4, 8'd5);
    wait_ready(g);
    check("rw_grant", g, 3);
    req_valid[3] = 1'b0;
    repeat (10) tick();
    check("rw_busy_wait", int'(busy), 1);
    do_reset();
    check("rw_busy_after", int'(busy), 0);
    check("rw_eng_a_after", int'(eng_a), 0);
    repeat (80) tick();
    check("rw_no_resp", resp_cnt, push_cnt);
    eng_delay = 4; eng_res = 8'd2;
    set_req(0, 8'd6, 8'd11);
    set_req(2, 8'd6, 8'd11);
    wait_ready(g);
    check("rw_grant_first", g, 0);
    expect_resp(0, 8'd2, 1'b0, 3 + 4);
    req_valid[0] = 1'b0;
    tick();
    wait_ready(g);
    check("rw_grant_second", g, 2);
    expect_resp(2, 8'd2, 1'b0, 3 + 4);
    req_valid[2] = 1'b0;
    tick();
    wait_drain();

`ifdef INV_ARB_ZERO_CHECK_EN
    eng_delay = 5; eng_res = 8'h55;
    s0 = start_cnt;
    set_req(2, 8'd0, 8'd7);
    wait_ready(g);
    check("zc_grant_a0", g, 2);
    expect_resp(2, 8'd0, 1'b1, 1);
    req_valid[2] = 1'b0;
    tick();
    wait_drain();
    set_req(1, 8'd5, 8'd1);
    wait_ready(g);
    check("zc_grant_p1", g, 1);
    expect_resp(1, 8'd0, 1'b1, 1);
    req_valid[1] = 1'b0;
    tick();
    wait_drain();
    repeat (3) tick();
    check("zc_no_start", start_cnt - s0, 0);
`endif

    repeat (3) tick();
    check("final_resp_count", resp_cnt, push_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inv_engine_arbiter.md
Name: inv_engine_arbiter

Overview:
- Shares one modular-inverse engine (8-bit operand `a`, 8-bit `prime`) between NUM_REQ requesters.
- Accepts one request at a time, chosen round-robin among pending requesters.
- Pulses the engine start, waits for completion or timeout, then returns the result to the winning requester.
- Sits between the key-schedule/ECC clients and the single shared inverse datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles in WAIT before aborting (>=2).
- CNT_W, 7, timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request pending; held until accepted.
- req_a  input  8*NUM_REQ  packed operand `a`; slice i = [8i+7:8i].
- req_prime  input  8*NUM_REQ  packed modulus; slice i = [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot, 1-cycle accept pulse.
- resp_valid  output  NUM_REQ  one-hot, 1-cycle response pulse to the owner.
- resp_data  output  8  inverse result; valid while any resp_valid bit is 1.
- resp_err  output  1  1 = timeout (or zero operand, see Optional Feature); valid with resp_valid.
- eng_start  output  1  1-cycle start pulse to the engine.
- eng_a  output  8  operand to the engine; held stable from ISSUE through end of WAIT.
- eng_prime  output  8  modulus to the engine; held stable from ISSUE through end of WAIT.
- eng_done  input  1  engine completion pulse.
- eng_result  input  8  engine result; sampled when eng_done=1.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (synchronous):
  - state=IDLE, rr_ptr=0, owner=0, timer=0.
  - req_ready, resp_valid, resp_err, eng_start, busy all 0.
  - resp_data, eng_a, eng_prime = 0.
- Arbitration:
  - Scan req_valid starting at rr_ptr, upward with wrap modulo NUM_REQ.
  - The first set bit wins.
  - rr_ptr <= owner+1 (mod NUM_REQ) on entry to RESP, so the last winner has lowest priority next time.
- States:
  - IDLE: if any req_valid, pulse req_ready[winner] this cycle, latch req_a/req_prime slices into eng_a/eng_prime, set owner=winner, go to ISSUE. Otherwise stay. Outputs are registered, so req_ready is seen the cycle after req_valid is sampled; a requester drops req_valid in the cycle after seeing req_ready.
  - ISSUE: eng_start=1 for exactly this cycle; timer<=0; go to WAIT.
  - WAIT:
    - If eng_done: latch eng_result into resp_data, resp_err<=0, go to RESP.
    - Else if timer==TIMEOUT-1: resp_data<=0, resp_err<=1, go to RESP.
    - Else timer<=timer+1.
    - If eng_done and the timeout fall in the same cycle, eng_done wins (err=0).
  - RESP: resp_valid[owner]=1 for one cycle; go to IDLE.
- Latency: accept to resp_valid = 1 (ISSUE) + k (WAIT cycles, including the done cycle) + 1 cycle. Back-to-back requests: the next req_ready comes at the earliest 1 cycle after RESP.
- eng_done seen in IDLE, ISSUE or RESP is ignored; a late done after a timeout is dropped.
- req_valid changes for non-winners during a transaction have no effect; those requesters keep waiting.
- Reset mid-operation: returns to IDLE in one cycle. No resp_valid is produced for the aborted request. The engine is not signalled, and its next stray done is ignored.
- resp_data and resp_err hold their value after RESP until the next update.

Optional Feature:
- Macro INV_ARB_ZERO_CHECK_EN.
- When defined: in IDLE, if the winner's a slice == 0 or prime slice < 2, the request is still accepted (req_ready pulse). The FSM skips ISSUE/WAIT and goes directly to RESP with resp_data=0, resp_err=1. eng_start stays 0, and response latency is 1 cycle after accept.
- When not defined: all operands go to the engine unchanged.

Test Plan:
- Single request, engine model: req 0 with a=3, prime=7; model asserts done after 5 cycles with result 5 -> req_ready[0] one pulse, eng_start one pulse, resp_valid[0] with resp_data=5, resp_err=0.
- Round-robin: all 4 requesting continuously, each with a=10, prime=17 (result 12) -> grant order 0,1,2,3,0. Every response is 12 on the matching resp_valid bit.
- Timeout: engine never asserts done, TIMEOUT=64 -> resp_valid[owner] exactly 66 cycles after the accept cycle, resp_data=0, resp_err=1. A done pulse injected afterwards is ignored.
- Coincident done and timeout at timer=63 with result 0x2A -> resp_data=0x2A, resp_err=0.
- Reset asserted in WAIT -> next cycle busy=0, no resp_valid. A fresh request afterwards completes normally with grant starting from requester 0.
- With INV_ARB_ZERO_CHECK_EN: req 2 with a=0, prime=7 -> eng_start never asserted, resp_valid[2] the cycle after req_ready[2], resp_err=1.
